// File: rtl/call_stack_sequencer_pkg.sv
// Shared definitions for the call/return stack sequencer: bus widths,
// stack page constants, FSM state type and the stack address helper.
package call_stack_sequencer_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 16;

  localparam logic [DATA_WIDTH-1:0] STACK_PAGE_DEFAULT = 8'h01;
  localparam logic [DATA_WIDTH-1:0] SP_RESET           = 8'hFF;

  // Deepest frame count the stack guard lets a push reach.
  localparam logic [7:0] MAX_FRAMES = 8'd127;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PH_REQ,
    ST_PH_WR_HI,
    ST_PH_WR_LO,
    ST_PP_RD_LO,
    ST_PP_RD_HI,
    ST_PP_LD_HI,
    ST_ERR
  } stack_state_t;

  // The stack never leaves its page: the pointer only supplies the low byte.
  function automatic logic [ADDR_WIDTH-1:0] stack_addr(
    input logic [DATA_WIDTH-1:0] page,
    input logic [DATA_WIDTH-1:0] ptr
  );
    return {page, ptr};
  endfunction

endpackage

// File: rtl/call_stack_sequencer_if.sv
// Bundle of the control-unit handshake, PC byte interface and RAM port
// seen by the stack sequencer. master = sequencer, slave = surroundings.
interface call_stack_sequencer_if;
  import call_stack_sequencer_pkg::*;

  logic                  push_req;
  logic                  pop_req;
  logic                  busy;
  logic                  done;
  logic                  pc_output_high_byte;
  logic                  pc_output_low_byte;
  logic [DATA_WIDTH-1:0] pc_byte_in;
  logic                  pc_load_high_byte;
  logic                  pc_load_low_byte;
  logic [DATA_WIDTH-1:0] pc_byte_out;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic                  mem_re;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] sp;
  logic                  err_overflow;
  logic                  err_underflow;

  modport master (
    input  push_req, pop_req, pc_byte_in, mem_rdata,
    output busy, done, pc_output_high_byte, pc_output_low_byte,
           pc_load_high_byte, pc_load_low_byte, pc_byte_out,
           mem_addr, mem_wdata, mem_we, mem_re, sp,
           err_overflow, err_underflow
  );

  modport slave (
    output push_req, pop_req, pc_byte_in, mem_rdata,
    input  busy, done, pc_output_high_byte, pc_output_low_byte,
           pc_load_high_byte, pc_load_low_byte, pc_byte_out,
           mem_addr, mem_wdata, mem_we, mem_re, sp,
           err_overflow, err_underflow
  );

endinterface

// File: rtl/call_stack_sequencer.sv
// Two-byte call/return stack engine. A push streams the PC out a byte at a
// time (high byte first, at the higher address) into a full-descending stack
// page; a pop reads the two bytes back and loads them into the PC.
// Optional macro STACK_GUARD_EN adds a frame counter that rejects pushes at
// 127 frames and pops at 0 frames with sticky overflow/underflow flags.
module call_stack_sequencer
  import call_stack_sequencer_pkg::*;
#(
  parameter logic [DATA_WIDTH-1:0] STACK_PAGE = STACK_PAGE_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset_n,
  call_stack_sequencer_if.master       bus
);

  stack_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] sp_q, sp_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pc_oh_q, pc_oh_d;
  logic                  pc_ol_q, pc_ol_d;
  logic                  pc_lh_q, pc_lh_d;
  logic                  pc_ll_q, pc_ll_d;
  logic                  we_q, we_d;
  logic                  re_q, re_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
`ifdef STACK_GUARD_EN
  logic [7:0]            depth_q, depth_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
`endif

  // Next state and pointer; requests are only looked at in IDLE, push first.
  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
`ifdef STACK_GUARD_EN
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.push_req) begin
`ifdef STACK_GUARD_EN
          if (depth_q == MAX_FRAMES) begin
            state_d = ST_ERR;
            ovf_d   = 1'b1;
          end else begin
            state_d = ST_PH_REQ;
          end
`else
          state_d = ST_PH_REQ;
`endif
        end else if (bus.pop_req) begin
`ifdef STACK_GUARD_EN
          if (depth_q == 8'd0) begin
            state_d = ST_ERR;
            unf_d   = 1'b1;
          end else begin
            state_d = ST_PP_RD_LO;
          end
`else
          state_d = ST_PP_RD_LO;
`endif
        end
      end
      ST_PH_REQ:   state_d = ST_PH_WR_HI;
      ST_PH_WR_HI: begin
        sp_d    = sp_q - 8'd1;
        state_d = ST_PH_WR_LO;
      end
      ST_PH_WR_LO: begin
        sp_d    = sp_q - 8'd1;
        state_d = ST_IDLE;
`ifdef STACK_GUARD_EN
        depth_d = depth_q + 8'd1;
`endif
      end
      ST_PP_RD_LO: begin
        sp_d    = sp_q + 8'd1;
        state_d = ST_PP_RD_HI;
      end
      ST_PP_RD_HI: begin
        sp_d    = sp_q + 8'd1;
        state_d = ST_PP_LD_HI;
      end
      ST_PP_LD_HI: begin
        state_d = ST_IDLE;
`ifdef STACK_GUARD_EN
        depth_d = depth_q - 8'd1;
`endif
      end
      ST_ERR:      state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Moore outputs of the state being entered, so the registered copies line
  // up with that state; the address uses the pointer value held during it.
  always_comb begin
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_PH_WR_LO) || (state_d == ST_PP_LD_HI) ||
              (state_d == ST_ERR);
    pc_oh_d = (state_d == ST_PH_REQ);
    pc_ol_d = (state_d == ST_PH_WR_HI);
    pc_ll_d = (state_d == ST_PP_RD_HI);
    pc_lh_d = (state_d == ST_PP_LD_HI);
    we_d    = (state_d == ST_PH_WR_HI) || (state_d == ST_PH_WR_LO);
    re_d    = (state_d == ST_PP_RD_LO) || (state_d == ST_PP_RD_HI);
    addr_d  = '0;
    case (state_d)
      ST_PH_WR_HI, ST_PH_WR_LO: addr_d = stack_addr(STACK_PAGE, sp_d);
      ST_PP_RD_LO, ST_PP_RD_HI: addr_d = stack_addr(STACK_PAGE, sp_d + 8'd1);
      default:                  addr_d = '0;
    endcase
  end

  // State, pointer and registered strobes; reset clears everything at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      sp_q    <= SP_RESET;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pc_oh_q <= 1'b0;
      pc_ol_q <= 1'b0;
      pc_lh_q <= 1'b0;
      pc_ll_q <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      addr_q  <= '0;
`ifdef STACK_GUARD_EN
      depth_q <= 8'd0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pc_oh_q <= pc_oh_d;
      pc_ol_q <= pc_ol_d;
      pc_lh_q <= pc_lh_d;
      pc_ll_q <= pc_ll_d;
      we_q    <= we_d;
      re_q    <= re_d;
      addr_q  <= addr_d;
`ifdef STACK_GUARD_EN
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
`endif
    end
  end

  assign bus.busy                = busy_q;
  assign bus.done                = done_q;
  assign bus.pc_output_high_byte = pc_oh_q;
  assign bus.pc_output_low_byte  = pc_ol_q;
  assign bus.pc_load_high_byte   = pc_lh_q;
  assign bus.pc_load_low_byte    = pc_ll_q;
  assign bus.mem_we              = we_q;
  assign bus.mem_re              = re_q;
  assign bus.mem_addr            = addr_q;
  assign bus.sp                  = sp_q;
  // Data paths are straight wires: PC bytes go to RAM, RAM bytes go to the PC.
  assign bus.mem_wdata           = bus.pc_byte_in;
  assign bus.pc_byte_out         = bus.mem_rdata;
`ifdef STACK_GUARD_EN
  assign bus.err_overflow        = ovf_q;
  assign bus.err_underflow       = unf_q;
`else
  assign bus.err_overflow        = 1'b0;
  assign bus.err_underflow       = 1'b0;
`endif

endmodule

// File: tb/tb_call_stack_sequencer.sv
// Bench for call_stack_sequencer: PC and RAM environment models, a stack
// reference model (byte array plus pointer arithmetic), a scoreboard queue
// filled at request time and a monitor that checks each completed operation.
module tb_call_stack_sequencer;
  import call_stack_sequencer_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  call_stack_sequencer_if bus();

  call_stack_sequencer #(.STACK_PAGE(8'h01)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- environment: program counter ----------------
  logic [15:0] pc_q = 16'h0000;
  logic [7:0]  pc_byte_q = 8'h00;
  logic        pc_en = 1'b0;
  logic [15:0] pc_en_val = 16'h0000;
  always @(posedge clk) begin
    if (pc_en) pc_q <= pc_en_val;
    else begin
      if (bus.pc_load_high_byte) pc_q[15:8] <= bus.pc_byte_out;
      if (bus.pc_load_low_byte)  pc_q[7:0]  <= bus.pc_byte_out;
    end
    if (bus.pc_output_high_byte)     pc_byte_q <= pc_q[15:8];
    else if (bus.pc_output_low_byte) pc_byte_q <= pc_q[7:0];
  end
  assign bus.pc_byte_in = pc_byte_q;

  // ---------------- environment: synchronous RAM ----------------
  logic [7:0] ram [0:65535];
  logic [7:0] rdata_q = 8'h00;
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) rdata_q <= ram[bus.mem_addr];
  end
  assign bus.mem_rdata = rdata_q;

  int n_we = 0;
  int n_re = 0;
  always @(posedge clk) begin
    if (bus.mem_we) n_we <= n_we + 1;
    if (bus.mem_re) n_re <= n_re + 1;
  end

  // ---------------- reference model ----------------
  typedef struct {
    bit          is_push;
    bit          is_err;
    logic [7:0]  exp_sp;
    logic [15:0] exp_pc;
    logic [7:0]  a_hi, a_lo, b_hi, b_lo;
    bit          exp_ovf, exp_unf;
    int          exp_we, exp_re;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] ref_mem [256];
  logic [7:0] ref_sp = 8'hFF;
  int         ref_depth = 0;
  bit         ref_ovf = 1'b0;
  bit         ref_unf = 1'b0;
  bit         guard_on;

  initial begin
`ifdef STACK_GUARD_EN
    guard_on = 1'b1;
`else
    guard_on = 1'b0;
`endif
  end

  function automatic exp_t model_op(input bit push, input bit pop, input logic [15:0] pcv);
    exp_t e;
    e = '{default: '0};
    e.is_push = push;
    if (push) begin
      if (guard_on && ref_depth == 127) begin
        e.is_err = 1'b1;
        ref_ovf  = 1'b1;
      end else begin
        e.a_hi = ref_sp;
        e.a_lo = 8'(ref_sp - 8'd1);
        e.b_hi = pcv[15:8];
        e.b_lo = pcv[7:0];
        ref_mem[e.a_hi] = e.b_hi;
        ref_mem[e.a_lo] = e.b_lo;
        ref_sp = 8'(ref_sp - 8'd2);
        ref_depth++;
        e.exp_we = 2;
      end
    end else if (pop) begin
      if (guard_on && ref_depth == 0) begin
        e.is_err = 1'b1;
        ref_unf  = 1'b1;
      end else begin
        e.exp_pc = {ref_mem[8'(ref_sp + 8'd2)], ref_mem[8'(ref_sp + 8'd1)]};
        ref_sp = 8'(ref_sp + 8'd2);
        ref_depth--;
        e.exp_re = 2;
      end
    end
    e.exp_sp  = ref_sp;
    e.exp_ovf = ref_ovf;
    e.exp_unf = ref_unf;
    return e;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    int   last_we;
    int   last_re;
    exp_t e;
    last_we = 0;
    last_re = 0;
    forever begin
      @(negedge clk);
      if (reset_n && bus.done) begin
        if (sbq.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
          @(posedge clk); #1;
        end else begin
          e = sbq.pop_front();
          @(posedge clk); #1;
          check("sp_after_op", 32'(bus.sp), 32'(e.exp_sp));
          check("err_overflow", 32'(bus.err_overflow), 32'(e.exp_ovf));
          check("err_underflow", 32'(bus.err_underflow), 32'(e.exp_unf));
          check("we_pulses", 32'(n_we - last_we), 32'(e.exp_we));
          check("re_pulses", 32'(n_re - last_re), 32'(e.exp_re));
          if (!e.is_err) begin
            if (e.is_push) begin
              check("ram_hi_byte", 32'(ram[{8'h01, e.a_hi}]), 32'(e.b_hi));
              check("ram_lo_byte", 32'(ram[{8'h01, e.a_lo}]), 32'(e.b_lo));
            end else begin
              check("pc_after_pop", 32'(pc_q), 32'(e.exp_pc));
            end
          end
        end
        last_we = n_we;
        last_re = n_re;
      end
    end
  end

  // Address discipline: page byte on every access, zero address when idle.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.mem_we || bus.mem_re) check("addr_page", 32'(bus.mem_addr[15:8]), 32'h01);
      if (!bus.busy) check("idle_addr", 32'(bus.mem_addr), 32'h0);
    end
  end

  // ---------------- driver ----------------
  task automatic do_op(input bit push, input bit pop, input logic [15:0] pcv, input bit hold_pop);
    int   cyc;
    exp_t e;
    cyc = 0;
    @(negedge clk);
    while (bus.busy && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (bus.busy) check("idle_wait_timeout", 32'd1, 32'd0);
    pc_en = 1'b1;
    pc_en_val = pcv;
    bus.push_req = push;
    bus.pop_req  = pop;
    e = model_op(push, pop, pcv);
    sbq.push_back(e);
    @(posedge clk); #1;
    pc_en = 1'b0;
    bus.push_req = 1'b0;
    bus.pop_req  = hold_pop;
    check("busy_after_accept", 32'(bus.busy), 32'd1);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.done && cyc < 10);
    bus.pop_req = 1'b0;
    check("done_latency", 32'(cyc), e.is_err ? 32'd1 : 32'd3);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    sbq.delete();
    ref_sp = 8'hFF;
    ref_depth = 0;
    ref_ovf = 1'b0;
    ref_unf = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int choice;
    bus.push_req = 1'b0;
    bus.pop_req  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_sp", 32'(bus.sp), 32'hFF);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'({bus.err_overflow, bus.err_underflow}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed push of 1234 then pop back.
    do_op(1'b1, 1'b0, 16'h1234, 1'b0);
    @(posedge clk); #2;
    check("push1234_ram_01ff", 32'(ram[16'h01FF]), 32'h12);
    check("push1234_ram_01fe", 32'(ram[16'h01FE]), 32'h34);
    check("push1234_sp", 32'(bus.sp), 32'hFD);
    do_op(1'b0, 1'b1, 16'h0000, 1'b0);
    @(posedge clk); #2;
    check("pop1234_pc", 32'(pc_q), 32'h1234);
    check("pop1234_sp", 32'(bus.sp), 32'hFF);

    // Simultaneous requests: push wins.
    do_op(1'b1, 1'b1, 16'hA55A, 1'b0);
    // Pop held during a busy push is ignored.
    do_op(1'b1, 1'b0, 16'h0F1E, 1'b1);
    @(negedge clk);
    check("held_pop_ignored_1", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("held_pop_ignored_2", 32'(bus.busy), 32'd0);

    // Asynchronous reset in the middle of a push.
    do_reset();
    @(negedge clk);
    pc_en = 1'b1;
    pc_en_val = 16'hBEEF;
    bus.push_req = 1'b1;
    @(posedge clk); #1;
    pc_en = 1'b0;
    bus.push_req = 1'b0;
    @(posedge clk); #1;
    check("abort_in_wr_hi", 32'(bus.mem_we), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_we", 32'(bus.mem_we), 32'd0);
    check("abort_strobe", 32'(bus.pc_output_low_byte), 32'd0);
    check("abort_addr", 32'(bus.mem_addr), 32'd0);
    check("abort_sp", 32'(bus.sp), 32'hFF);
    sbq.delete();
    ref_sp = 8'hFF;
    ref_depth = 0;
    ref_ovf = 1'b0;
    ref_unf = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    do_op(1'b1, 1'b0, 16'hC0DE, 1'b0);
    do_op(1'b0, 1'b1, 16'h0000, 1'b0);

    // Randomised mix of pushes and pops.
    for (int i = 0; i < 40; i++) begin
      choice = int'($urandom_range(0, 2));
      if (ref_depth == 0 || (choice == 0 && ref_depth < 120))
        do_op(1'b1, 1'b0, 16'($urandom), 1'b0);
      else if (choice == 1 && ref_depth < 120)
        do_op(1'b1, 1'b1, 16'($urandom), 1'b0);
      else
        do_op(1'b0, 1'b1, 16'($urandom), 1'b0);
    end

    // Depth limits.
    do_reset();
`ifdef STACK_GUARD_EN
    do_op(1'b0, 1'b1, 16'h1111, 1'b0);
    for (int i = 0; i < 128; i++) do_op(1'b1, 1'b0, 16'($urandom), 1'b0);
    @(posedge clk); #2;
    check("guard_full_sp", 32'(bus.sp), 32'h01);
    check("guard_ovf", 32'(bus.err_overflow), 32'd1);
    check("guard_unf", 32'(bus.err_underflow), 32'd1);
`else
    for (int i = 0; i < 129; i++) do_op(1'b1, 1'b0, 16'($urandom), 1'b0);
    @(posedge clk); #2;
    check("wrap_sp", 32'(bus.sp), 32'hFD);
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
